// File: rtl/des_key_sched.sv
// -----------------------------------------------------------------------------
// des_key_sched -- DES round-subkey generator with a valid/ready output stream.
//
// A start pulse in IDLE latches a 64-bit key and a direction flag. The block
// then presents one 48-bit PC-2 subkey per round: K1..K16 for encryption, or
// K16..K1 for decryption. It advances one round on every accepted handshake.
//
// Ports
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset
//   start        : one-cycle request; only honoured while idle
//   key[63:0]    : DES key with parity bits (key[63] is FIPS bit 1)
//   decrypt      : sampled with start; 1 = emit K16 first
//   subkey[47:0] : current subkey (subkey[47] is PC-2 output bit 1)
//   subkey_valid : subkey/round/last are valid
//   subkey_ready : downstream accepts the presented subkey
//   round[3:0]   : emission index 0..15
//   last         : marks the 16th subkey
//   busy         : sequence in progress
//   parity_err   : key parity flag, registered on an accepted start
//
// Build option
//   DES_KEY_PARITY_CHECK_EN : when defined, parity_err is set if any key byte
//   has even parity. When undefined, parity_err is tied to 0.
// -----------------------------------------------------------------------------
module des_key_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] key,
  input  logic        decrypt,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round,
  output logic        last,
  output logic        busy,
  output logic        parity_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // PC-1 source positions, in FIPS numbering (bit 1 = MSB of the key).
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // PC-2 source positions within the 56-bit C||D value (bit 1 = MSB of C).
  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Permuted choice 1: 64-bit key -> 56-bit C||D. The first table entry
  // becomes the MSB of the result.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    logic [5:0]  idx;
    r = 56'd0;
    for (int i = 0; i < 56; i++) begin
      idx = 6'(64 - PC1_TAB[i]);
      r   = {r[54:0], k[idx]};
    end
    return r;
  endfunction

  // Permuted choice 2: 56-bit C||D -> 48-bit subkey.
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    logic [5:0]  idx;
    r = 48'd0;
    for (int i = 0; i < 48; i++) begin
      idx = 6'(56 - PC2_TAB[i]);
      r   = {r[46:0], cd[idx]};
    end
    return r;
  endfunction

  // Left rotation moves bits toward FIPS bit 1, which is the MSB here.
  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic        decrypt_r;
  logic [27:0] c_r;
  logic [27:0] d_r;
  logic [47:0] subkey_r;
  logic [3:0]  round_r;
  logic        last_r;

  logic        accept_s;
  logic        handshake_s;
  logic [55:0] cd_load_s;
  logic [27:0] c_first_s;
  logic [27:0] d_first_s;
  logic        shift2_s;
  logic [27:0] c_step_s;
  logic [27:0] d_step_s;

  assign accept_s    = (state_r == IDLE) && start;
  assign handshake_s = (state_r == RUN) && subkey_ready;

  // First-round C/D: encryption pre-rotates by one. Decryption starts from
  // the PC-1 value itself, because 28 cumulative rotations give back C16/D16.
  always_comb begin
    cd_load_s = pc1(key);
    if (decrypt) begin
      c_first_s = cd_load_s[55:28];
      d_first_s = cd_load_s[27:0];
    end else begin
      c_first_s = rotl(cd_load_s[55:28], 1'b0);
      d_first_s = rotl(cd_load_s[27:0], 1'b0);
    end
  end

  // Next-round C/D. The next round index is 1, 8 or 15 (single-bit shift)
  // exactly when the current index is 0, 7 or 14. This holds in both
  // directions.
  always_comb begin
    shift2_s = !((round_r == 4'd0) || (round_r == 4'd7) || (round_r == 4'd14));
    if (decrypt_r) begin
      c_step_s = rotr(c_r, shift2_s);
      d_step_s = rotr(d_r, shift2_s);
    end else begin
      c_step_s = rotl(c_r, shift2_s);
      d_step_s = rotl(d_r, shift2_s);
    end
  end

  // Next-state logic for the IDLE/RUN controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (handshake_s && last_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Round datapath: load on start, step on handshake, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decrypt_r <= 1'b0;
      c_r       <= 28'd0;
      d_r       <= 28'd0;
      subkey_r  <= 48'd0;
      round_r   <= 4'd0;
      last_r    <= 1'b0;
    end else if (accept_s) begin
      decrypt_r <= decrypt;
      c_r       <= c_first_s;
      d_r       <= d_first_s;
      subkey_r  <= pc2({c_first_s, d_first_s});
      round_r   <= 4'd0;
      last_r    <= 1'b0;
    end else if (handshake_s) begin
      if (last_r) begin
        round_r <= 4'd0;
        last_r  <= 1'b0;
      end else begin
        c_r      <= c_step_s;
        d_r      <= d_step_s;
        subkey_r <= pc2({c_step_s, d_step_s});
        round_r  <= round_r + 4'd1;
        last_r   <= (round_r == 4'd14);
      end
    end else begin
      subkey_r <= subkey_r;
    end
  end

  assign subkey       = subkey_r;
  assign round        = round_r;
  assign last         = last_r;
  assign busy         = (state_r == RUN);
  assign subkey_valid = (state_r == RUN);

`ifdef DES_KEY_PARITY_CHECK_EN
  // DES keys use odd parity per byte; any even-parity byte flags an error.
  function automatic logic key_parity_bad(input logic [63:0] k);
    logic        bad;
    logic [63:0] t;
    bad = 1'b0;
    t   = k;
    for (int b = 0; b < 8; b++) begin
      bad = bad | ~(^t[7:0]);
      t   = t >> 8;
    end
    return bad;
  endfunction

  logic parity_err_r;

  // Parity flag: captured on each accepted start and held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_r <= 1'b0;
    end else if (accept_s) begin
      parity_err_r <= key_parity_bad(key);
    end else begin
      parity_err_r <= parity_err_r;
    end
  end

  assign parity_err = parity_err_r;
`else
  // PC-1 drops the parity bits, so they are unused when checking is disabled.
  logic unused_parity_bits_s;
  assign unused_parity_bits_s = ^{key[56], key[48], key[40], key[32],
                                  key[24], key[16], key[8], key[0]};
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_sched.sv
module tb_des_key_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] key = 64'd0;
  logic        decrypt = 1'b0;
  logic        subkey_ready = 1'b0;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round;
  logic        last;
  logic        busy;
  logic        parity_err;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [63:0] KEY_GOOD  = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BAD   = 64'h123457799BBCDFF1;
  localparam logic [63:0] KEY_OTHER = 64'h0E329232EA6D0D73;

  // Subkeys K1..K16 for KEY_GOOD, from the standard worked DES example.
  localparam logic [47:0] KS [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

`ifdef DES_KEY_PARITY_CHECK_EN
  localparam logic EXP_BAD_PAR = 1'b1;
`else
  localparam logic EXP_BAD_PAR = 1'b0;
`endif

  always #5 clk = ~clk;

  des_key_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .key          (key),
    .decrypt      (decrypt),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round        (round),
    .last         (last),
    .busy         (busy),
    .parity_err   (parity_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_round(input string tag, input int r, input logic [47:0] exp_sk);
    chk({tag, " subkey"}, 64'(subkey), 64'(exp_sk));
    chk({tag, " round"}, 64'(round), 64'(r));
    chk({tag, " last"}, 64'(last), 64'(r == 15));
    chk({tag, " valid"}, 64'(subkey_valid), 64'd1);
    chk({tag, " busy"}, 64'(busy), 64'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " valid"}, 64'(subkey_valid), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " last"}, 64'(last), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk_idle(tag);
    chk({tag, " subkey"}, 64'(subkey), 64'd0);
    chk({tag, " round"}, 64'(round), 64'd0);
    chk({tag, " parity"}, 64'(parity_err), 64'd0);
  endtask

  task automatic do_start(input logic [63:0] k, input logic dec);
    start = 1'b1;
    key = k;
    decrypt = dec;
    tick();
    start = 1'b0;
    key = 64'd0;
    decrypt = 1'b0;
  endtask

  initial begin
    // Reset state while rst_n is held low.
    #2;
    chk_zero("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk_zero("post_reset");

    // Encrypt: K1..K16 with ready held high.
    subkey_ready = 1'b1;
    do_start(KEY_GOOD, 1'b0);
    for (int r = 0; r < 16; r++) begin
      chk_round("enc", r, KS[r]);
      tick();
    end
    chk_idle("enc_done");
    chk("enc parity", 64'(parity_err), 64'd0);
    tick();
    chk_idle("enc_done2");

    // Decrypt: K16..K1.
    do_start(KEY_GOOD, 1'b1);
    for (int r = 0; r < 16; r++) begin
      chk_round("dec", r, KS[15 - r]);
      tick();
    end
    chk_idle("dec_done");

    // Encrypt with a stall at round 3, a stray start at round 7, and a start
    // in the same cycle as the final handshake.
    do_start(KEY_GOOD, 1'b0);
    for (int r = 0; r < 16; r++) begin
      chk_round("enc2", r, KS[r]);
      if (r == 3) begin
        subkey_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          chk_round("stall", 3, KS[3]);
        end
        subkey_ready = 1'b1;
      end
      if (r == 7 || r == 15) begin
        start = 1'b1;
        key = KEY_OTHER;
        decrypt = 1'b1;
      end
      tick();
      start = 1'b0;
      key = 64'd0;
      decrypt = 1'b0;
    end
    chk_idle("enc2_done");
    tick();
    chk_idle("enc2_start_ignored");

    // Reset asserted at round 9 aborts the sequence.
    do_start(KEY_GOOD, 1'b0);
    for (int r = 0; r < 9; r++) begin
      tick();
    end
    chk_round("pre_abort", 9, KS[9]);
    rst_n = 1'b0;
    #1;
    chk_zero("abort");
    #2 rst_n = 1'b1;
    tick();
    chk_zero("abort_idle");
    tick();
    chk_zero("abort_idle2");
    do_start(KEY_GOOD, 1'b0);
    chk_round("restart", 0, KS[0]);
    repeat (16) tick();
    chk_idle("restart_done");

    // Parity flag: bad key, then good key.
    do_start(KEY_BAD, 1'b0);
    chk("parity bad", 64'(parity_err), 64'(EXP_BAD_PAR));
    chk("parity bad valid", 64'(subkey_valid), 64'd1);
    repeat (16) tick();
    chk_idle("parity_bad_done");
    chk("parity bad held", 64'(parity_err), 64'(EXP_BAD_PAR));
    do_start(KEY_GOOD, 1'b0);
    chk("parity good", 64'(parity_err), 64'd0);
    chk_round("parity_good_k1", 0, KS[0]);
    repeat (16) tick();
    chk_idle("parity_good_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
